// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port owner: round-robin host/coprocessor arbitration plus a fill-with-constant clear engine.
// Optional FB_VBLANK_GATE_EN restricts all writes to cycles where vblank is high (tear-free updates).
module fb_write_arbiter #(
  parameter int   ADDR_W    = 12,
  parameter int   DEPTH     = 4096,
  parameter logic CLEAR_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_data,
  output logic              host_ack,
  input  logic              cop_req,
  input  logic [ADDR_W-1:0] cop_addr,
  input  logic              cop_data,
  output logic              cop_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              vblank,
  output logic [ADDR_W-1:0] wraddress,
  output logic              data,
  output logic              wren
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ptr_q, ptr_d;       // 0: host wins next tie, 1: coprocessor wins
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;
  logic              data_q, data_d;
  logic              host_ack_q, host_ack_d;
  logic              cop_ack_q, cop_ack_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic              grant_host, grant_cop;
  logic              write_ok;

`ifdef FB_VBLANK_GATE_EN
  assign write_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign write_ok      = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    wren_d      = 1'b0;
    wraddress_d = '0;
    data_d      = 1'b0;
    host_ack_d  = 1'b0;
    cop_ack_d   = 1'b0;
    clr_busy_d  = 1'b0;
    clr_done_d  = 1'b0;
    grant_host  = host_req & (~cop_req | ~ptr_q);
    grant_cop   = cop_req & ~grant_host;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          clr_busy_d = 1'b1;
        end else if (write_ok && (grant_host || grant_cop)) begin
          wren_d      = 1'b1;
          wraddress_d = grant_host ? host_addr : cop_addr;
          data_d      = grant_host ? host_data : cop_data;
          host_ack_d  = grant_host;
          cop_ack_d   = grant_cop;
          ptr_d       = grant_host;
        end
      end
      CLEAR: begin
        clr_busy_d = 1'b1;
        // Counter parked at DEPTH means the last write has gone out; spend one cycle dropping busy.
        if (cnt_q == CNT_W'(DEPTH)) begin
          state_d    = IDLE;
          clr_busy_d = 1'b0;
        end else if (write_ok) begin
          wren_d      = 1'b1;
          wraddress_d = cnt_q[ADDR_W-1:0];
          data_d      = CLEAR_VAL;
          clr_done_d  = (cnt_q == CNT_W'(DEPTH - 1));
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      wren_q      <= 1'b0;
      wraddress_q <= '0;
      data_q      <= 1'b0;
      host_ack_q  <= 1'b0;
      cop_ack_q   <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      wren_q      <= wren_d;
      wraddress_q <= wraddress_d;
      data_q      <= data_d;
      host_ack_q  <= host_ack_d;
      cop_ack_q   <= cop_ack_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
    end
  end

  assign wren      = wren_q;
  assign wraddress = wraddress_q;
  assign data      = data_q;
  assign host_ack  = host_ack_q;
  assign cop_ack   = cop_ack_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: vector table for arbitration, hand sequences for clear, reset and vblank.
module tb_fb_write_arbiter;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_req, host_data, cop_req, cop_data, clr_start, vblank;
  logic [ADDR_W-1:0] host_addr, cop_addr;
  logic              host_ack, cop_ack, clr_busy, clr_done, data, wren;
  logic [ADDR_W-1:0] wraddress;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_VAL(1'b0)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .cop_req(cop_req), .cop_addr(cop_addr), .cop_data(cop_data), .cop_ack(cop_ack),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .vblank(vblank),
    .wraddress(wraddress), .data(data), .wren(wren)
  );

  typedef struct {
    logic              hreq;
    logic [ADDR_W-1:0] haddr;
    logic              hdat;
    logic              creq;
    logic [ADDR_W-1:0] caddr;
    logic              cdat;
    logic              ewren;
    logic [ADDR_W-1:0] eaddr;
    logic              edat;
    logic              ehack;
    logic              ecack;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string name, input logic ew, input logic [ADDR_W-1:0] ea,
                            input logic ed, input logic eh, input logic ec);
    check({name, "_wren"}, 32'(wren), 32'(ew));
    check({name, "_addr"}, 32'(wraddress), 32'(ea));
    check({name, "_data"}, 32'(data), 32'(ed));
    check({name, "_host_ack"}, 32'(host_ack), 32'(eh));
    check({name, "_cop_ack"}, 32'(cop_ack), 32'(ec));
  endtask

  initial begin
    int bad;
    int acks;

    reset = 1'b1; clr_start = 1'b0; vblank = 1'b1;
    host_req = 1'b1; host_addr = 12'h0A5; host_data = 1'b1;
    cop_req = 1'b0; cop_addr = '0; cop_data = 1'b0;

    // Reset state, with a host request pending that must not be acked while in reset
    repeat (3) step();
    check_port("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("reset_busy", 32'(clr_busy), 32'd0);
    check("reset_done", 32'(clr_done), 32'd0);

    reset = 1'b0;
    step();
    check_port("first_host", 1'b1, 12'h0A5, 1'b1, 1'b1, 1'b0);

    // After the first host grant the coprocessor owns the next tie
    vecs[0] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h123, 1'b1, 1'b1, 12'h123, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 12'h010, 1'b0, 1'b1, 12'h020, 1'b1, 1'b1, 12'h010, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 12'h010, 1'b0, 1'b1, 12'h020, 1'b1, 1'b1, 12'h020, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 12'h010, 1'b0, 1'b1, 12'h020, 1'b1, 1'b1, 12'h010, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 12'h010, 1'b0, 1'b1, 12'h020, 1'b1, 1'b1, 12'h020, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 12'hFFF, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 12'h001, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 12'h002, 1'b0, 1'b1, 12'h003, 1'b1, 1'b1, 12'h003, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      host_req = vecs[i].hreq; host_addr = vecs[i].haddr; host_data = vecs[i].hdat;
      cop_req  = vecs[i].creq; cop_addr  = vecs[i].caddr; cop_data  = vecs[i].cdat;
      step();
      check_port($sformatf("vec%0d", i), vecs[i].ewren, vecs[i].eaddr, vecs[i].edat,
                 vecs[i].ehack, vecs[i].ecack);
    end

    // vblank low with a host request pending
    vblank = 1'b0; host_req = 1'b1; host_addr = 12'h055; host_data = 1'b1;
`ifdef FB_VBLANK_GATE_EN
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (host_ack || wren) acks++;
    end
    check("vblank_low_no_ack", 32'(acks), 32'd0);
    vblank = 1'b1;
    step();
    check_port("vblank_high_ack", 1'b1, 12'h055, 1'b1, 1'b1, 1'b0);
`else
    acks = 0;
    step();
    check_port("vblank_ignored", 1'b1, 12'h055, 1'b1, 1'b1, 1'b0);
`endif
    host_req = 1'b0; vblank = 1'b1;
    step();

    // Full clear, started together with a coprocessor request that must wait
    clr_start = 1'b1; cop_req = 1'b1; cop_addr = 12'h777; cop_data = 1'b1;
    step();
    clr_start = 1'b0;
    check("clr_busy_rise", 32'(clr_busy), 32'd1);
    check_port("clr_start_cycle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      if (wren !== 1'b1 || wraddress !== ADDR_W'(k) || data !== 1'b0 || cop_ack !== 1'b0 ||
          host_ack !== 1'b0 || clr_busy !== 1'b1 || clr_done !== (k == DEPTH - 1))
        bad++;
    end
    check("clear_sweep_bad_cycles", 32'(bad), 32'd0);
    check("clr_done_last", 32'(clr_done), 32'd1);
    check("clr_last_addr", 32'(wraddress), 32'hFFF);
    step();
    check("clr_busy_fall", 32'(clr_busy), 32'd0);
    check("clr_done_fall", 32'(clr_done), 32'd0);
    check_port("clr_exit", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    check_port("cop_after_clear", 1'b1, 12'h777, 1'b1, 1'b0, 1'b1);
    cop_req = 1'b0;
    step();

    // Reset at clear address 100; a clr_start mid-clear must not restart the sweep
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    bad = 0;
    for (int k = 0; k <= 100; k++) begin
      step();
      if (wren !== 1'b1 || wraddress !== ADDR_W'(k) || clr_busy !== 1'b1) bad++;
      clr_start = (k == 50);
    end
    check("midclear_sweep_bad_cycles", 32'(bad), 32'd0);
    check("midclear_addr100", 32'(wraddress), 32'd100);
    reset = 1'b1;
    step();
    check("reset_midclear_wren", 32'(wren), 32'd0);
    check("reset_midclear_busy", 32'(clr_busy), 32'd0);
    reset = 1'b0; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    check("restart_busy", 32'(clr_busy), 32'd1);
    step();
    check_port("restart_addr0", 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
